// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Address/data words, RISC-V load/store size codes, port select.
package mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-side signals of the arbiter.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic       if_valid;
    addr_t      if_address;
    logic       if_ready;
    logic       if_rsp_valid;
    data_t      if_rsp_data;
    logic       if_rsp_error;

    logic       d_valid;
    logic       d_write;
    logic [2:0] d_funct3;
    addr_t      d_address;
    data_t      d_write_data;
    logic       d_ready;
    logic       d_rsp_valid;
    data_t      d_rsp_data;
    logic       d_rsp_error;

    addr_t      mem_address;
    data_t      mem_write_data;
    logic [3:0] mem_write_enable;
    data_t      mem_read_data;

    modport slave (
        input  if_valid, if_address,
        output if_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
        input  d_valid, d_write, d_funct3, d_address, d_write_data,
        output d_ready, d_rsp_valid, d_rsp_data, d_rsp_error,
        output mem_address, mem_write_data, mem_write_enable,
        input  mem_read_data
    );

    modport master (
        output if_valid, if_address,
        input  if_ready, if_rsp_valid, if_rsp_data, if_rsp_error,
        output d_valid, d_write, d_funct3, d_address, d_write_data,
        input  d_ready, d_rsp_valid, d_rsp_data, d_rsp_error,
        input  mem_address, mem_write_data, mem_write_enable,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Illegal size codes or misaligned accesses yield no lanes and zero data.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic       write_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    input  data_t      wdata_i,
    input  data_t      rdata_i,
    output logic [3:0] wen_o,
    output data_t      wdata_o,
    output data_t      rdata_o,
    output logic       error_o
);

    logic  legal;
    data_t shifted;

    always_comb begin
        legal   = 1'b0;
        wen_o   = '0;
        wdata_o = wdata_i;
        rdata_o = '0;
        shifted = rdata_i >> {addr_lo_i, 3'b000};

        case (funct3_i)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !addr_lo_i[0];
            F3_W:    legal = (addr_lo_i == 2'b00);
            F3_BU:   legal = !write_i;
            F3_HU:   legal = !write_i && !addr_lo_i[0];
            default: legal = 1'b0;
        endcase

        if (legal && write_i) begin
            case (funct3_i)
                F3_B: begin
                    wen_o   = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    wen_o   = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_W:    wen_o = 4'b1111;
                default: wen_o = '0;
            endcase
        end

        if (legal && !write_i) begin
            case (funct3_i)
                F3_B:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
                F3_BU: rdata_o = {24'd0, shifted[7:0]};
                F3_H:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
                F3_HU: rdata_o = {16'd0, shifted[15:0]};
                F3_W:  rdata_o = rdata_i;
                default: rdata_o = '0;
            endcase
        end

        error_o = !legal;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between
// instruction fetch and load/store, one access outstanding at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic RR_INIT = 1'b1
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);

    state_e     state_q;
    port_e      last_q;
    port_e      rsp_port_q;
    logic       rsp_write_q;
    logic [2:0] rsp_f3_q;
    logic [1:0] rsp_alo_q;

    logic       idle;
    logic       gnt_if;
    logic       gnt_d;
    logic       req_write;
    logic [2:0] req_f3;
    addr_t      req_addr;
    logic [3:0] req_wen;
    data_t      req_wdata;
    data_t      req_rdata_unused;
    logic       req_err_unused;

    logic [3:0] rsp_wen_unused;
    data_t      rsp_wdata_unused;
    data_t      rsp_data;
    logic       rsp_err;

    // Ties go to whichever port was not granted last.
    always_comb begin
        idle      = (state_q == IDLE) && !reset;
        gnt_if    = idle && bus.if_valid &&
                    (!bus.d_valid || last_q == PORT_D);
        gnt_d     = idle && bus.d_valid &&
                    (!bus.if_valid || last_q == PORT_IF);
        req_write = gnt_d && bus.d_write;
        req_f3    = gnt_d ? bus.d_funct3 : F3_W;
        req_addr  = gnt_if ? bus.if_address :
                    gnt_d  ? bus.d_address  : '0;
    end

    mem_lane_align u_req_align (
        .write_i   (req_write),
        .funct3_i  (req_f3),
        .addr_lo_i (req_addr[1:0]),
        .wdata_i   (bus.d_write_data),
        .rdata_i   ('0),
        .wen_o     (req_wen),
        .wdata_o   (req_wdata),
        .rdata_o   (req_rdata_unused),
        .error_o   (req_err_unused)
    );

    mem_lane_align u_rsp_align (
        .write_i   (rsp_write_q),
        .funct3_i  (rsp_f3_q),
        .addr_lo_i (rsp_alo_q),
        .wdata_i   ('0),
        .rdata_i   (bus.mem_read_data),
        .wen_o     (rsp_wen_unused),
        .wdata_o   (rsp_wdata_unused),
        .rdata_o   (rsp_data),
        .error_o   (rsp_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= port_e'(RR_INIT);
            rsp_port_q  <= PORT_IF;
            rsp_write_q <= 1'b0;
            rsp_f3_q    <= F3_W;
            rsp_alo_q   <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_if || gnt_d) begin
                        state_q     <= RESP;
                        last_q      <= gnt_d ? PORT_D : PORT_IF;
                        rsp_port_q  <= gnt_d ? PORT_D : PORT_IF;
                        rsp_write_q <= req_write;
                        rsp_f3_q    <= req_f3;
                        rsp_alo_q   <= req_addr[1:0];
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.if_ready         = gnt_if;
        bus.d_ready          = gnt_d;
        bus.mem_address      = req_addr;
        bus.mem_write_enable = req_wen;
        bus.mem_write_data   = req_wdata;

        bus.if_rsp_valid = (state_q == RESP) && (rsp_port_q == PORT_IF);
        bus.d_rsp_valid  = (state_q == RESP) && (rsp_port_q == PORT_D);
        bus.if_rsp_data  = bus.if_rsp_valid ? rsp_data : '0;
        bus.d_rsp_data   = bus.d_rsp_valid  ? rsp_data : '0;
        bus.if_rsp_error = bus.if_rsp_valid && rsp_err;
        bus.d_rsp_error  = bus.d_rsp_valid  && rsp_err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard of
// expected responses, tie alternation and reset-in-response sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        fetch;
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  wen;
        logic [31:0] lane;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t v[18];
    logic [31:0] mem [0:63];

    mem_arbiter_if bus ();

    mem_arbiter #(.RR_INIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory: registered read, per-byte write, preloaded under reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h00A00093;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'h0080FF00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_write_enable[i])
                    mem[bus.mem_address[7:2]][8*i +: 8] <=
                        bus.mem_write_data[8*i +: 8];
        end
        bus.mem_read_data <= mem[bus.mem_address[7:2]];
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_onehot",
            {31'd0, bus.if_ready && bus.d_ready}, 32'd0);
        if (bus.if_rsp_valid || bus.d_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp",
                    {30'd0, bus.d_rsp_valid, bus.if_rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {31'd0, bus.d_rsp_valid},
                    {31'd0, e.port});
                chk("rsp_data",
                    e.port ? bus.d_rsp_data : bus.if_rsp_data, e.data);
                chk("rsp_err",
                    {31'd0, e.port ? bus.d_rsp_error : bus.if_rsp_error},
                    {31'd0, e.err});
            end
        end
    end

    function automatic vec_t mk(logic fe, logic wr, logic [2:0] f3,
                                logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic er,
                                logic [3:0] we, logic [31:0] ln);
        vec_t r;
        r.fetch = fe; r.write = wr; r.f3 = f3; r.addr = a;
        r.wdata = wd; r.rdata = rd; r.err = er; r.wen = we;
        r.lane = ln;
        return r;
    endfunction

    task automatic issue(input vec_t x);
        bit got;
        exp_t e;
        got = 1'b0;
        @(negedge clk);
        if (x.fetch) begin
            bus.if_valid   = 1'b1;
            bus.if_address = x.addr;
        end else begin
            bus.d_valid      = 1'b1;
            bus.d_write      = x.write;
            bus.d_funct3     = x.f3;
            bus.d_address    = x.addr;
            bus.d_write_data = x.wdata;
        end
        for (int n = 0; n < 8 && !got; n++) begin
            #1;
            if (x.fetch ? bus.if_ready : bus.d_ready) begin
                got = 1'b1;
                chk("mem_wen", {28'd0, bus.mem_write_enable},
                    {28'd0, x.wen});
                chk("mem_addr", bus.mem_address, x.addr);
                if (x.wen != 4'd0)
                    chk("mem_wdata", bus.mem_write_data, x.lane);
                e.port = !x.fetch;
                e.data = x.rdata;
                e.err  = x.err;
                sb.push_back(e);
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        v[0]  = mk(1, 0, F3_W,   32'h10, 0, 32'h00A00093, 0, 4'h0, 0);
        v[1]  = mk(0, 1, F3_B,   32'h23, 32'hAB, 0, 0, 4'b1000,
                   32'hABABABAB);
        v[2]  = mk(0, 0, F3_W,   32'h20, 0, 32'hAB223344, 0, 4'h0, 0);
        v[3]  = mk(0, 0, F3_B,   32'h32, 0, 32'hFFFFFF80, 0, 4'h0, 0);
        v[4]  = mk(0, 0, F3_BU,  32'h32, 0, 32'h00000080, 0, 4'h0, 0);
        v[5]  = mk(0, 0, F3_H,   32'h32, 0, 32'h00000080, 0, 4'h0, 0);
        v[6]  = mk(0, 1, F3_H,   32'h21, 32'h5555, 0, 1, 4'h0, 0);
        v[7]  = mk(0, 1, 3'b011, 32'h20, 32'h77, 0, 1, 4'h0, 0);
        v[8]  = mk(0, 0, F3_W,   32'h20, 0, 32'hAB223344, 0, 4'h0, 0);
        v[9]  = mk(1, 0, F3_W,   32'h12, 0, 32'h0, 1, 4'h0, 0);
        v[10] = mk(0, 1, F3_W,   32'h40, 32'hDEADBEEF, 0, 0, 4'hF,
                   32'hDEADBEEF);
        v[11] = mk(0, 1, F3_H,   32'h42, 32'h1234, 0, 0, 4'b1100,
                   32'h12341234);
        v[12] = mk(0, 0, F3_W,   32'h40, 0, 32'h1234BEEF, 0, 4'h0, 0);
        v[13] = mk(0, 0, F3_HU,  32'h42, 0, 32'h00001234, 0, 4'h0, 0);
        v[14] = mk(0, 0, F3_H,   32'h40, 0, 32'hFFFFBEEF, 0, 4'h0, 0);
        v[15] = mk(0, 0, F3_W,   32'h41, 0, 32'h0, 1, 4'h0, 0);
        v[16] = mk(0, 0, F3_B,   32'h43, 0, 32'h00000012, 0, 4'h0, 0);
        v[17] = mk(0, 0, 3'b110, 32'h40, 0, 32'h0, 1, 4'h0, 0);

        reset            = 1'b1;
        bus.if_valid     = 1'b1;
        bus.if_address   = 32'h10;
        bus.d_valid      = 1'b1;
        bus.d_write      = 1'b0;
        bus.d_funct3     = F3_W;
        bus.d_address    = 32'h20;
        bus.d_write_data = 32'h0;

        // Reset state with both requests pending.
        repeat (3) @(negedge clk);
        chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
        chk("rst_d_ready",  {31'd0, bus.d_ready}, 32'd0);
        chk("rst_wen", {28'd0, bus.mem_write_enable}, 32'd0);
        chk("rst_rsp_valid",
            {30'd0, bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.d_rsp_data | bus.if_rsp_data, 32'd0);
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;
        reset = 1'b0;
        #1;
        chk("idle_addr", bus.mem_address, 32'd0);

        // Simultaneous requests held: F, -, D, -, F, -, D, -.
        @(negedge clk);
        bus.if_valid = 1'b1;
        bus.d_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("tie_if_ready", {31'd0, bus.if_ready},
                (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("tie_d_ready", {31'd0, bus.d_ready},
                (k % 4 == 2) ? 32'd1 : 32'd0);
            if (bus.if_ready) begin
                e.port = 1'b0; e.data = 32'h00A00093; e.err = 1'b0;
                sb.push_back(e);
            end
            if (bus.d_ready) begin
                e.port = 1'b1; e.data = 32'h11223344; e.err = 1'b0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;

        for (int i = 0; i < 18; i++) issue(v[i]);

        // Reset during the response cycle of a load.
        @(negedge clk);
        @(negedge clk);
        bus.d_valid   = 1'b1;
        bus.d_write   = 1'b0;
        bus.d_funct3  = F3_W;
        bus.d_address = 32'h20;
        #1;
        chk("rr_d_ready", {31'd0, bus.d_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.if_valid   = 1'b1;
        bus.if_address = 32'h10;
        repeat (2) begin
            @(negedge clk);
            chk("rr_readies", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
            chk("rr_d_rsp", {31'd0, bus.d_rsp_valid}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("rr_after_if", {31'd0, bus.if_ready}, 32'd1);
        chk("rr_after_d", {31'd0, bus.d_ready}, 32'd0);
        if (bus.if_ready) begin
            e.port = 1'b0; e.data = 32'h00A00093; e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;

        for (int n = 0; n < 6 && sb.size() != 0; n++) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
